// File: rtl/cnn_pkg.sv
// Shared constants and loader state encoding for the image buffer and pooling engine.
package cnn_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MAX_PIXELS = 1024;
  localparam int unsigned SIZE_W     = 16;
  localparam int unsigned ADDR_W     = $clog2(MAX_PIXELS);
  localparam int unsigned CNT_W      = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

endpackage

// File: rtl/pixel_addr_counter.sv
// Pixel write counter with terminal-count detect against the latched frame size.
module pixel_addr_counter #(
  parameter int unsigned CntW = 11
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            inc_i,
  input  logic [CntW-1:0] total_i,
  output logic [CntW-1:0] count_o,
  output logic            last_pixel_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Compare count+1 so a total of zero never matches through underflow.
  assign last_pixel_o = ((count_q + CntW'(1)) == total_i);

endmodule

// File: rtl/image_buffer_loader.sv
// Fills a row-major imgSize x imgSize frame buffer from a valid/ready pixel stream
// and raises 'loaded' for the pooling engine once the frame is complete.
module image_buffer_loader
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_W-1:0]        imgSize,
  input  logic                     inValid,
  input  logic signed [DATA_W-1:0] inData,
  output logic                     inReady,
  output logic signed [DATA_W-1:0] image [0:MAX_PIXELS-1],
  output logic [CNT_W-1:0]         writeIdx,
  output logic                     busy,
  output logic                     loaded,
  output logic                     err
);

  loader_state_t           state_q;
  logic [CNT_W-1:0]        total_q;
  logic [2*SIZE_W-1:0]     total_full;
  logic                    size_ok;
  logic                    start_ok;
  logic                    accept;
  logic                    last_pixel;

  // Full-width square so oversized sides cannot alias into a small total.
  assign total_full = {{SIZE_W{1'b0}}, imgSize} * {{SIZE_W{1'b0}}, imgSize};
  assign size_ok    = (total_full != '0) && (total_full <= (2*SIZE_W)'(MAX_PIXELS));
  assign start_ok   = start && size_ok && (state_q != LOAD);
  assign accept     = inValid && inReady;

  pixel_addr_counter #(
    .CntW (CNT_W)
  ) u_counter (
    .clk_i        (clk),
    .rst_ni       (reset),
    .clear_i      (start_ok),
    .inc_i        (accept),
    .total_i      (total_q),
    .count_o      (writeIdx),
    .last_pixel_o (last_pixel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      total_q <= '0;
      inReady <= 1'b0;
      busy    <= 1'b0;
      loaded  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (size_ok) begin
              state_q <= LOAD;
              total_q <= total_full[CNT_W-1:0];
              inReady <= 1'b1;
              busy    <= 1'b1;
              loaded  <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept && last_pixel) begin
            state_q <= DONE;
            inReady <= 1'b0;
            busy    <= 1'b0;
            loaded  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          inReady <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // accept implies writeIdx < total <= MAX_PIXELS, so the low bits address the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_PIXELS; i++) begin
        image[i] <= '0;
      end
    end else if (accept) begin
      image[writeIdx[ADDR_W-1:0]] <= inData;
    end
  end

endmodule

// File: tb/tb_image_buffer_loader.sv
// Self-checking bench for image_buffer_loader: cycle model plus write scoreboard.
module tb_image_buffer_loader;
  import cnn_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [SIZE_W-1:0]        imgSize;
  logic                     inValid;
  logic signed [DATA_W-1:0] inData;
  logic                     inReady;
  logic signed [DATA_W-1:0] image [0:MAX_PIXELS-1];
  logic [CNT_W-1:0]         writeIdx;
  logic                     busy;
  logic                     loaded;
  logic                     err;

  image_buffer_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .imgSize  (imgSize),
    .inValid  (inValid),
    .inData   (inData),
    .inReady  (inReady),
    .image    (image),
    .writeIdx (writeIdx),
    .busy     (busy),
    .loaded   (loaded),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned      idx;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [SIZE_W-1:0] size;
    bit                exp_err;
  } vec_t;

  wr_t  sb[$];
  vec_t vt[6];

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_load, m_loaded, m_err;
  int unsigned m_cnt, m_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nonzero_words();
    int n = 0;
    for (int i = 0; i < MAX_PIXELS; i++) begin
      if (image[i] !== '0) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the reference model advanced from pre-edge inputs.
  task automatic step();
    bit          acc, ok, st_ok, st_bad;
    logic [31:0] tot;
    tot    = 32'(imgSize) * 32'(imgSize);
    ok     = (tot != 0) && (tot <= MAX_PIXELS);
    acc    = inValid && m_load;
    st_ok  = start && !m_load && ok;
    st_bad = start && !m_load && !ok;
    tick();
    if (acc) begin
      sb.push_back('{m_cnt, inData});
      m_cnt++;
      if (m_cnt == m_total) begin
        m_load   = 1'b0;
        m_loaded = 1'b1;
      end
    end
    if (st_ok) begin
      m_load   = 1'b1;
      m_cnt    = 0;
      m_total  = tot;
      m_loaded = 1'b0;
    end
    m_err = st_bad;
    check("inReady", 32'(inReady), 32'(m_load));
    check("busy", 32'(busy), 32'(m_load));
    check("loaded", 32'(loaded), 32'(m_loaded));
    check("err", 32'(err), 32'(m_err));
    check("writeIdx", 32'(writeIdx), m_cnt);
  endtask

  task automatic chk_reset_state();
    check("rst_inReady", 32'(inReady), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_writeIdx", 32'(writeIdx), 32'd0);
    check("rst_image_nonzero", 32'(nonzero_words()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk_reset_state();
    start    = 1'b0;
    inValid  = 1'b0;
    m_load   = 1'b0;
    m_loaded = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 0;
    m_total  = 0;
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic run_start(input logic [SIZE_W-1:0] size);
    start   = 1'b1;
    imgSize = size;
    inValid = 1'b0;
    step();
    start = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] pix(input int mode, input int unsigned idx);
    case (mode)
      0:       return (idx == 3) ? 16'hA000 : 16'h0400;
      1:       return DATA_W'($urandom);
      default: return DATA_W'(idx) ^ 16'h5A5A;
    endcase
  endfunction

  // Feed pixels until the model leaves LOAD or stop_at pixels are taken.
  task automatic feed(input int mode, input bit gaps, input int unsigned stop_at);
    int c = 0;
    while (m_load && m_cnt < stop_at && c < 5000) begin
      inValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      inData  = pix(mode, m_cnt);
      step();
      c++;
    end
    check("feed_budget", 32'(c < 5000), 32'd1);
  endtask

  task automatic drain();
    wr_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("scoreboard_word", 32'($unsigned(image[e.idx])), 32'(e.data));
    end
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    imgSize = '0;
    inValid = 1'b0;
    inData  = '0;
    m_load = 0; m_loaded = 0; m_err = 0; m_cnt = 0; m_total = 0;

    vt[0] = '{16'd0,     1'b1};
    vt[1] = '{16'd33,    1'b1};
    vt[2] = '{16'd65535, 1'b1};
    vt[3] = '{16'd1,     1'b0};
    vt[4] = '{16'd32,    1'b0};
    vt[5] = '{16'd31,    1'b0};

    #12;
    chk_reset_state();
    reset = 1'b1;

    // Pixels offered while idle are ignored.
    inValid = 1'b1;
    inData  = 16'h1234;
    step();
    step();
    inValid = 1'b0;

    // Size-check table: bad sizes pulse err for one cycle and stay idle.
    for (int i = 0; i < 6; i++) begin
      run_start(vt[i].size);
      check("size_err", 32'(err), 32'(vt[i].exp_err));
      check("size_busy", 32'(busy), 32'(!vt[i].exp_err));
      step();
      check("size_err_pulse", 32'(err), 32'd0);
      do_reset();
    end

    // 10x10 frame, inValid held high past the last pixel.
    run_start(16'd10);
    feed(0, 1'b0, 32'hFFFF_FFFF);
    check("t2_loaded", 32'(loaded), 32'd1);
    check("t2_writeIdx", 32'(writeIdx), 32'd100);
    check("t2_img3", 32'($unsigned(image[3])), 32'h0000_A000);
    check("t2_writes", 32'(sb.size()), 32'd100);
    for (int i = 0; i < 2; i++) step();
    drain();

    // 4x4 frame with random gaps, then valid held high in DONE.
    run_start(16'd4);
    feed(1, 1'b1, 32'hFFFF_FFFF);
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t3_writes", 32'(sb.size()), 32'd16);
    check("t3_inReady_done", 32'(inReady), 32'd0);
    drain();
    inValid = 1'b0;

    // Full-depth frame: last word written, index 0 not overwritten.
    run_start(16'd32);
    feed(2, 1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) step();
    check("t5_writeIdx", 32'(writeIdx), 32'd1024);
    check("t5_img1023", 32'($unsigned(image[1023])), 32'(16'h5A5A ^ 16'd1023));
    check("t5_img0", 32'($unsigned(image[0])), 32'h0000_5A5A);
    drain();
    inValid = 1'b0;

    // Start during LOAD is ignored.
    run_start(16'd5);
    feed(1, 1'b0, 3);
    start   = 1'b1;
    imgSize = 16'd7;
    inValid = 1'b1;
    inData  = pix(1, m_cnt);
    step();
    start = 1'b0;
    feed(1, 1'b0, 32'hFFFF_FFFF);
    check("t6_first_writes", 32'(sb.size()), 32'd25);
    drain();

    // Back-to-back start from DONE drops loaded, then reload.
    run_start(16'd5);
    check("t6_loaded_fall", 32'(loaded), 32'd0);
    feed(2, 1'b1, 32'hFFFF_FFFF);
    check("t6_loaded_rise", 32'(loaded), 32'd1);
    drain();

    // Reset mid-frame aborts and zeroes the buffer.
    run_start(16'd5);
    feed(1, 1'b0, 7);
    check("t6_mid_writeIdx", 32'(writeIdx), 32'd7);
    do_reset();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
